alu_sequencer: RTL

Upstream control stage for the 8-bit ALU. Accepts encoded instructions over a valid/ready handshake and holds a 4-entry × 8-bit register file and a flag register. It drives the ALU's opcode and operand inputs from registers, then captures the combinational result and the Zero/Carry/Negative flags back into the register file one cycle later. Throughput is one instruction per two cycles.

---
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/retire control stage in front of an 8-bit ALU.
// Holds a 4x8 register file and NCZ flags, one instruction per two cycles.
module alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DATA_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_negative,
  output logic               done,
  output logic [2:0]         flags,
  output logic               err,
  input  logic [1:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  logic [0:0]        state;
  logic [3:0]        op_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] rf [4];

  logic [3:0]        in_op;
  logic              in_isel;
  logic [1:0]        in_rd;
  logic [1:0]        in_rs;
  logic [DATA_W-1:0] in_imm;
  logic              unused_rsvd;

  assign in_op       = in_instr[19:16];
  assign in_isel     = in_instr[15];
  assign in_rd       = in_instr[14:13];
  assign in_rs       = in_instr[12:11];
  assign in_imm      = in_instr[7:0];
  assign unused_rsvd = ^in_instr[10:8];

  logic accept;
  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;

  logic cls_alu;
  logic cls_ldi;
  logic cls_nop;
  logic cls_ill;

  assign cls_alu = (op_q[3] == 1'b0);
  assign cls_ldi = (op_q == 4'h8);
  assign cls_nop = (op_q == 4'h9);
  assign cls_ill = (op_q >= 4'hA);

  logic              wr_rf;
  logic              wr_flags;
  logic              set_err;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_rf    = 1'b0;
    wr_flags = 1'b0;
    set_err  = 1'b0;
    wr_data  = alu_result;
    unique case (1'b1)
      cls_alu: begin
        wr_rf    = 1'b1;
        wr_flags = 1'b1;
      end
      cls_ldi: begin
        wr_rf   = 1'b1;
        wr_data = imm_q;
      end
      cls_nop: begin
        wr_rf = 1'b0;
      end
      cls_ill: begin
        set_err = 1'b1;
      end
      default: begin
        set_err = 1'b1;
      end
    endcase
  end

  // Operands are sampled from rf at accept, so rd == rs reads the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      done       <= 1'b0;
      flags      <= 3'b000;
      err        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            op_q       <= in_op;
            rd_q       <= in_rd;
            imm_q      <= in_imm;
            alu_opcode <= {{(DATA_W-4){1'b0}}, in_op};
            alu_a      <= rf[in_rd];
            alu_b      <= in_isel ? in_imm : rf[in_rs];
          end
        end
        EXEC: begin
          state <= IDLE;
          done  <= 1'b1;
          if (wr_rf) begin
            rf[rd_q] <= wr_data;
          end
          if (wr_flags) begin
            flags <= {alu_negative, alu_carry, alu_zero};
          end
          if (set_err) begin
            err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_data = rf[dbg_sel];

endmodule
